// File: rtl/fp_norm_round_pipe.sv
// Three-stage normalise-and-round back end for the floating-point adder.
// Stage 1 counts leading zeros, stage 2 shifts and extracts guard/round/sticky, stage 3 rounds and packs.
module fp_norm_round_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int EXTRA = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_sign,
   input  logic [EXP_W-1:0]       in_exp,
   input  logic [MAN_W+EXTRA:0]   in_sum,
   input  logic                   in_carry,
   input  logic [1:0]             in_rm,
   input  logic                   in_special,
   input  logic [EXP_W+MAN_W:0]   in_special_word,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_word,
   output logic                   out_overflow,
   output logic                   out_underflow,
   output logic                   out_inexact
);

   localparam int ALIGN_W = MAN_W + 1 + EXTRA;
   localparam int LZ_W    = $clog2(ALIGN_W + 1);
   // Two spare exponent bits absorb the carry path and the rounding carry before the overflow test.
   localparam int EW      = EXP_W + 2;
   localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
   localparam logic [ALIGN_W-2:0] LOW_MASK = ((ALIGN_W-1)'(1) << (EXTRA - 2)) - (ALIGN_W-1)'(1);

   typedef enum logic [1:0] {
      RM_RNE = 2'd0,
      RM_RTZ = 2'd1,
      RM_RUP = 2'd2,
      RM_RDN = 2'd3
   } rm_t;

   logic advance;

   logic                 s1_valid, s1_sign, s1_carry, s1_special, s1_zero;
   logic [EXP_W-1:0]     s1_exp;
   logic [ALIGN_W-1:0]   s1_sum;
   rm_t                  s1_rm;
   logic [EXP_W+MAN_W:0] s1_special_word;
   logic [LZ_W-1:0]      s1_lzc;

   logic                 s2_valid, s2_sign, s2_special, s2_zero;
   logic                 s2_guard, s2_round, s2_sticky;
   logic [EW-1:0]        s2_exp;
   logic [MAN_W-1:0]     s2_man;
   rm_t                  s2_rm;
   logic [EXP_W+MAN_W:0] s2_special_word;

   logic [LZ_W-1:0]      in_lzc;
   logic                 in_zero;

   logic [EW-1:0]        exp_ext, lzc_ext, n_exp;
   logic [ALIGN_W-2:0]   norm;
   logic                 shift_out;

   logic                 inc, lost, to_inf, ovf;
   logic [EW+MAN_W-1:0]  rounded;
   logic [EW-1:0]        r_exp;
   logic [MAN_W-1:0]     r_man;
   logic [EXP_W+MAN_W:0] n_word;
   logic                 n_ovf, n_unf, n_inx;

   function automatic logic [LZ_W-1:0] lead_zeros(input logic [ALIGN_W-1:0] v);
      logic [LZ_W-1:0] n;
      n = LZ_W'(ALIGN_W);
      for (int i = 0; i < ALIGN_W; i++) begin
         if (v[i]) n = LZ_W'(ALIGN_W - 1 - i);
      end
      return n;
   endfunction

   // A stalled output freezes the whole pipe; bubbles travel like operands.
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   assign in_lzc  = lead_zeros(in_sum);
   assign in_zero = ~in_carry & ~(|in_sum);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else if (advance) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         s1_sign         <= in_sign;
         s1_exp          <= in_exp;
         s1_sum          <= in_sum;
         s1_carry        <= in_carry;
         s1_rm           <= rm_t'(in_rm);
         s1_special      <= in_special;
         s1_zero         <= in_zero;
         s1_special_word <= in_special_word;
         s1_lzc          <= in_lzc;
         s2_sign         <= s1_sign;
         s2_exp          <= n_exp;
         s2_man          <= norm[ALIGN_W-2 -: MAN_W];
         s2_guard        <= norm[EXTRA-1];
         s2_round        <= norm[EXTRA-2];
         s2_sticky       <= (|(norm & LOW_MASK)) | shift_out;
         s2_rm           <= s1_rm;
         s2_special      <= s1_special;
         s2_zero         <= s1_zero;
         s2_special_word <= s1_special_word;
      end
   end

   // Left shifts that would drive the exponent below 1 stop at the subnormal scale instead.
   always_comb begin
      exp_ext   = EW'(s1_exp);
      lzc_ext   = EW'(s1_lzc);
      norm      = (ALIGN_W-1)'(s1_sum);
      shift_out = 1'b0;
      n_exp     = '0;
      if (s1_carry) begin
         norm      = s1_sum[ALIGN_W-1:1];
         shift_out = s1_sum[0];
         n_exp     = exp_ext + EW'(1);
      end else if (lzc_ext < exp_ext) begin
         norm  = (ALIGN_W-1)'(s1_sum << s1_lzc);
         n_exp = exp_ext - lzc_ext;
      end else if (s1_exp != '0) begin
         norm  = (ALIGN_W-1)'(s1_sum << (s1_exp - EXP_W'(1)));
         n_exp = '0;
      end
   end

   // Rounding adds into {exponent, mantissa} so a mantissa carry bumps the exponent,
   // which also lifts a subnormal into the smallest normal.
   always_comb begin
      lost = s2_guard | s2_round | s2_sticky;
      inc  = 1'b0;
      case (s2_rm)
         RM_RNE: inc = s2_guard & (s2_round | s2_sticky | s2_man[0]);
         RM_RTZ: inc = 1'b0;
         RM_RUP: inc = ~s2_sign & lost;
         RM_RDN: inc = s2_sign & lost;
         default: inc = 1'b0;
      endcase
      rounded = {s2_exp, s2_man} + (EW+MAN_W)'(inc);
      r_exp   = rounded[EW+MAN_W-1:MAN_W];
      r_man   = rounded[MAN_W-1:0];
      ovf     = (r_exp >= EXP_MAX);
      to_inf  = (s2_rm == RM_RNE) | ((s2_rm == RM_RUP) & ~s2_sign) | ((s2_rm == RM_RDN) & s2_sign);
      n_word  = {s2_sign, r_exp[EXP_W-1:0], r_man};
      n_ovf   = ovf;
      n_inx   = lost | ovf;
      n_unf   = (lost | ovf) & ((r_exp == '0) | (s2_exp == '0));
      if (ovf) begin
         if (to_inf) n_word = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         else        n_word = {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      end
      if (s2_zero) begin
         n_word = {(s2_rm == RM_RDN), {(EXP_W+MAN_W){1'b0}}};
         n_ovf  = 1'b0;
         n_unf  = 1'b0;
         n_inx  = 1'b0;
      end
      if (s2_special) begin
         n_word = s2_special_word;
         n_ovf  = 1'b0;
         n_unf  = 1'b0;
         n_inx  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_word      <= '0;
         out_overflow  <= 1'b0;
         out_underflow <= 1'b0;
         out_inexact   <= 1'b0;
      end else if (advance && s2_valid) begin
         out_word      <= n_word;
         out_overflow  <= n_ovf;
         out_underflow <= n_unf;
         out_inexact   <= n_inx;
      end
   end

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Bench for fp_norm_round_pipe: directed cases, backpressure, reset, and random traffic
// checked against a real-valued rounding model.
module tb_fp_norm_round_pipe;

   localparam logic [1:0] RNE = 2'd0;
   localparam logic [1:0] RTZ = 2'd1;
   localparam logic [1:0] RUP = 2'd2;
   localparam logic [1:0] RDN = 2'd3;

   typedef struct {
      logic [31:0] word;
      logic        ovf;
      logic        unf;
      logic        inx;
   } res_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_ready, in_sign, in_carry, in_special;
   logic [7:0]  in_exp;
   logic [31:0] in_sum, in_special_word;
   logic [1:0]  in_rm;
   logic        out_valid, out_ready;
   logic [31:0] out_word;
   logic        out_overflow, out_underflow, out_inexact;

   res_t expq[$];
   res_t pend;
   logic accepted;
   int   errors = 0;
   int   checks = 0;

   fp_norm_round_pipe dut (
      .clk(clk),
      .reset_n(reset_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_sign(in_sign),
      .in_exp(in_exp),
      .in_sum(in_sum),
      .in_carry(in_carry),
      .in_rm(in_rm),
      .in_special(in_special),
      .in_special_word(in_special_word),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_word(out_word),
      .out_overflow(out_overflow),
      .out_underflow(out_underflow),
      .out_inexact(out_inexact)
   );

   always #5 clk = ~clk;

   // Works on the exact value {carry,sum} * 2^(exp-31): find the unit in the last place
   // for the result scale, then round the integer quotient by comparing the remainder with half.
   function automatic res_t refModel(input logic s, input logic [7:0] e, input logic [31:0] sum,
                                     input logic c, input logic [1:0] rm, input logic sp,
                                     input logic [31:0] sw);
      res_t   r;
      longint m, q, rem, half, enc;
      int     p, ee, ulp, fexp;
      logic   up, inx;
      r.word = 32'd0;
      r.ovf  = 1'b0;
      r.unf  = 1'b0;
      r.inx  = 1'b0;
      if (sp) begin
         r.word = sw;
         return r;
      end
      m = longint'({31'd0, c, sum});
      if (m == 0) begin
         r.word = {(rm == RDN), 31'd0};
         return r;
      end
      p = 0;
      for (int i = 0; i <= 32; i++) if (m[i]) p = i;
      ee  = int'(e) + p - 31;
      ulp = (ee >= 1) ? (p - 23) : (p - 22 - ee);
      if (ulp > 0) begin
         q    = m >> ulp;
         rem  = m - (q << ulp);
         half = longint'(1) << (ulp - 1);
      end else begin
         q    = m << (-ulp);
         rem  = 0;
         half = 1;
      end
      inx = (rem != 0);
      case (rm)
         RNE:     up = (rem > half) || ((rem == half) && q[0]);
         RTZ:     up = 1'b0;
         RUP:     up = !s && inx;
         default: up = s && inx;
      endcase
      enc = (ee >= 1) ? ((longint'(ee) << 23) + q - (longint'(1) << 23)) : q;
      if (up) enc = enc + 1;
      fexp = int'(enc >> 23);
      if (fexp >= 255) begin
         r.ovf = 1'b1;
         r.inx = 1'b1;
         if (rm == RNE || (rm == RUP && !s) || (rm == RDN && s)) r.word = {s, 8'hFF, 23'd0};
         else r.word = {s, 8'hFE, 23'h7FFFFF};
      end else begin
         r.inx  = inx;
         r.word = {s, enc[30:0]};
         r.unf  = inx && (ee < 1 || fexp == 0);
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [31:0] sum,
                                input logic c, input logic [1:0] rm, input logic sp,
                                input logic [31:0] sw);
      in_valid        = 1'b1;
      in_sign         = s;
      in_exp          = e;
      in_sum          = sum;
      in_carry        = c;
      in_rm           = rm;
      in_special      = sp;
      in_special_word = sw;
      pend            = refModel(s, e, sum, c, rm, sp, sw);
   endtask

   task automatic randomStimulus();
      logic [7:0]  e;
      logic [31:0] sum;
      e   = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 40)) : 8'($urandom_range(1, 255));
      sum = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) sum = 32'd0;
      applyStimulus(1'($urandom), e, sum, ($urandom_range(0, 3) == 0), 2'($urandom),
                    ($urandom_range(0, 19) == 0), $urandom);
   endtask

   // One clock: settle, score a consumed output, queue an accepted input, then step past the edge.
   task automatic cycle();
      res_t e;
      #1;
      accepted = 1'b0;
      if (out_valid && out_ready) begin
         if (expq.size() == 0) begin
            checkOutput("spurious_out_valid", 32'(out_valid), 32'd0);
         end else begin
            e = expq.pop_front();
            checkOutput("word", out_word, e.word);
            checkOutput("overflow", 32'(out_overflow), 32'(e.ovf));
            checkOutput("underflow", 32'(out_underflow), 32'(e.unf));
            checkOutput("inexact", 32'(out_inexact), 32'(e.inx));
         end
      end
      if (in_valid && in_ready) begin
         expq.push_back(pend);
         accepted = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic sendOne();
      int k;
      k = 0;
      cycle();
      while (!accepted && k < 50) begin
         cycle();
         k++;
      end
      if (!accepted) checkOutput("accept_timeout", 32'(accepted), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && expq.size() > 0; k++) cycle();
      checkOutput("drain_empty", 32'(expq.size()), 32'd0);
   endtask

   initial begin
      $display("[TB] start");
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; accepted = 1'b0;
      in_sign = 1'b0; in_exp = 8'd0; in_sum = 32'd0; in_carry = 1'b0;
      in_rm = RNE; in_special = 1'b0; in_special_word = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_word", out_word, 32'd0);
      checkOutput("rst_flags", {29'd0, out_overflow, out_underflow, out_inexact}, 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

      // Carry path, also timing out_valid relative to the accept cycle.
      out_ready = 1'b1;
      applyStimulus(1'b0, 8'h7F, 32'h8000_0000, 1'b1, RNE, 1'b0, 32'd0);
      pend = '{word: 32'h4040_0000, ovf: 1'b0, unf: 1'b0, inx: 1'b0};
      cycle();
      in_valid = 1'b0;
      checkOutput("lat_cycle1", 32'(out_valid), 32'd0);
      cycle();
      checkOutput("lat_cycle2", 32'(out_valid), 32'd0);
      cycle();
      checkOutput("lat_cycle3", 32'(out_valid), 32'd1);
      cycle();

      applyStimulus(1'b0, 8'h7F, 32'h0000_8000, 1'b0, RNE, 1'b0, 32'd0);
      pend = '{word: 32'h3780_0000, ovf: 1'b0, unf: 1'b0, inx: 1'b0};
      sendOne();
      applyStimulus(1'b0, 8'h7F, 32'h8000_0180, 1'b0, RNE, 1'b0, 32'd0);
      pend = '{word: 32'h3F80_0002, ovf: 1'b0, unf: 1'b0, inx: 1'b1};
      sendOne();
      applyStimulus(1'b0, 8'h7F, 32'h8000_0180, 1'b0, RTZ, 1'b0, 32'd0);
      pend = '{word: 32'h3F80_0001, ovf: 1'b0, unf: 1'b0, inx: 1'b1};
      sendOne();
      applyStimulus(1'b1, 8'h7F, 32'h8000_0180, 1'b0, RDN, 1'b0, 32'd0);
      pend = '{word: 32'hBF80_0002, ovf: 1'b0, unf: 1'b0, inx: 1'b1};
      sendOne();
      applyStimulus(1'b0, 8'hFE, 32'h0000_0000, 1'b1, RNE, 1'b0, 32'd0);
      pend = '{word: 32'h7F80_0000, ovf: 1'b1, unf: 1'b0, inx: 1'b1};
      sendOne();
      applyStimulus(1'b0, 8'hFE, 32'h0000_0000, 1'b1, RTZ, 1'b0, 32'd0);
      pend = '{word: 32'h7F7F_FFFF, ovf: 1'b1, unf: 1'b0, inx: 1'b1};
      sendOne();
      applyStimulus(1'b0, 8'h03, 32'h0000_8000, 1'b0, RNE, 1'b0, 32'd0);
      pend = '{word: 32'h0000_0200, ovf: 1'b0, unf: 1'b0, inx: 1'b0};
      sendOne();
      applyStimulus(1'b0, 8'h40, 32'h0000_0000, 1'b0, RDN, 1'b0, 32'd0);
      pend = '{word: 32'h8000_0000, ovf: 1'b0, unf: 1'b0, inx: 1'b0};
      sendOne();
      applyStimulus(1'b0, 8'hFE, 32'h8000_00FF, 1'b1, RUP, 1'b1, 32'h7FC0_0000);
      pend = '{word: 32'h7FC0_0000, ovf: 1'b0, unf: 1'b0, inx: 1'b0};
      sendOne();
      drain();

      // Three operands into a stalled output, then a fourth waiting on in_ready.
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         randomStimulus();
         cycle();
         checkOutput("bp_fill_accept", 32'(accepted), 32'd1);
      end
      randomStimulus();
      checkOutput("bp_full_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_full_out_valid", 32'(out_valid), 32'd1);
      cycle();
      checkOutput("bp_no_accept", 32'(accepted), 32'd0);
      cycle();
      checkOutput("bp_word_held", out_word, expq[0].word);
      out_ready = 1'b1;
      cycle();
      checkOutput("bp_resume_accept", 32'(accepted), 32'd1);
      in_valid = 1'b0;
      drain();
      repeat (3) cycle();
      checkOutput("bp_no_duplicate", 32'(out_valid), 32'd0);

      // Random traffic with random backpressure; inputs hold until accepted.
      accepted = 1'b1;
      for (int n = 0; n < 400; n++) begin
         out_ready = ($urandom_range(0, 9) < 7);
         if (!in_valid || accepted) begin
            if ($urandom_range(0, 3) != 0) randomStimulus();
            else in_valid = 1'b0;
         end
         cycle();
      end
      out_ready = 1'b1;
      if (in_valid && !accepted) sendOne();
      in_valid = 1'b0;
      drain();

      // Park an overflow result at the output, then reset with work in flight.
      out_ready = 1'b0;
      applyStimulus(1'b1, 8'hFE, 32'h0000_0000, 1'b1, RNE, 1'b0, 32'd0);
      sendOne();
      randomStimulus();
      cycle();
      in_valid = 1'b0;
      repeat (2) cycle();
      checkOutput("pre_rst_overflow", 32'(out_overflow), 32'd1);
      reset_n = 1'b0;
      randomStimulus();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      in_valid = 1'b0;
      expq.delete();
      checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_rst_out_word", out_word, 32'd0);
      checkOutput("mid_rst_flags", {29'd0, out_overflow, out_underflow, out_inexact}, 32'd0);
      checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      repeat (4) cycle();
      checkOutput("mid_rst_dropped", 32'(out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
